// File: rtl/mult_div_unit_if.sv
//------------------------------------------------------------------------------
// Module   : mult_div_unit_if
// Brief    : Start/operand/result bundle between the control unit and
//            mult_div_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             MultInit;
  logic             DivInit;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             MultStop;
  logic             DivStop;
  logic             DivZero;
  logic             Busy;

  modport master (
    output MultInit, DivInit, A_in, B_in,
    input  Hi, Lo, MultStop, DivStop, DivZero, Busy
  );

  modport slave (
    input  MultInit, DivInit, A_in, B_in,
    output Hi, Lo, MultStop, DivStop, DivZero, Busy
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
//------------------------------------------------------------------------------
// Module   : mult_div_unit
// Brief    : Iterative shift-add multiplier / restoring divider, one bit per
//            clock. Define MULTDIV_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       Reset_In,
  mult_div_unit_if.slave  bus
);

  localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_DIV   = 3'd2,
    S_DONE  = 3'd3,
    S_DZERO = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_work_hi;
  logic [WIDTH-1:0]   r_work_lo;
  logic [WIDTH-1:0]   r_operand;
  logic               r_is_mult;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_mult_stop;
  logic               r_div_stop;
  logic               r_div_zero;
  logic               r_busy;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic               w_last;

`ifdef MULTDIV_SIGNED_EN
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [2*WIDTH-1:0] w_prod;

  // Iteration always works on magnitudes; -2^(W-1) maps onto itself, which is
  // the correct unsigned magnitude.
  assign w_a_mag = bus.A_in[WIDTH-1] ? (~bus.A_in + 1'b1) : bus.A_in;
  assign w_b_mag = bus.B_in[WIDTH-1] ? (~bus.B_in + 1'b1) : bus.B_in;
`else
  assign w_a_mag = bus.A_in;
  assign w_b_mag = bus.B_in;
`endif

  assign w_last = (r_cnt == c_LAST);

  // One iteration of either algorithm, selected by the latched op type.
  always_comb begin
    w_sum     = {1'b0, r_work_hi} + (r_work_lo[0] ? {1'b0, r_operand} : '0);
    w_shift   = {r_work_hi, r_work_lo[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_operand});
    w_step_hi = '0;
    w_step_lo = '0;
    if (r_is_mult) begin
      w_step_hi = w_sum[WIDTH:1];
      w_step_lo = {w_sum[0], r_work_lo[WIDTH-1:1]};
    end else begin
      // When w_ge holds the true difference is below 2^W, so W-bit math is exact.
      w_step_hi = w_ge ? (w_shift[WIDTH-1:0] - r_operand) : w_shift[WIDTH-1:0];
      w_step_lo = {r_work_lo[WIDTH-2:0], w_ge};
    end
  end

`ifdef MULTDIV_SIGNED_EN
  always_comb begin
    w_prod   = {w_step_hi, w_step_lo};
    w_res_hi = w_step_hi;
    w_res_lo = w_step_lo;
    if (r_is_mult) begin
      if (r_neg_res) begin
        w_prod   = ~w_prod + 1'b1;
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
      end
    end else begin
      if (r_neg_res) w_res_lo = ~w_step_lo + 1'b1;
      if (r_neg_rem) w_res_hi = ~w_step_hi + 1'b1;
    end
  end
`else
  assign w_res_hi = w_step_hi;
  assign w_res_lo = w_step_lo;
`endif

  always_ff @(posedge clk or negedge Reset_In) begin
    if (!Reset_In) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.MultInit)
          w_state_next = S_MULT;
        else if (bus.DivInit)
          w_state_next = (bus.B_in == '0) ? S_DZERO : S_DIV;
      end
      S_MULT, S_DIV: if (w_last) w_state_next = S_DONE;
      S_DONE, S_DZERO: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_In) begin
    if (!Reset_In) begin
      r_cnt       <= '0;
      r_work_hi   <= '0;
      r_work_lo   <= '0;
      r_operand   <= '0;
      r_is_mult   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_mult_stop <= 1'b0;
      r_div_stop  <= 1'b0;
      r_div_zero  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
`endif
    end else begin
      // Strobes are registered from the next state so they never glitch.
      r_mult_stop <= (w_state_next == S_DONE) && (r_state == S_MULT);
      r_div_stop  <= ((w_state_next == S_DONE) && (r_state == S_DIV)) ||
                     (w_state_next == S_DZERO);
      r_div_zero  <= (w_state_next == S_DZERO);
      r_busy      <= (w_state_next == S_MULT) || (w_state_next == S_DIV) ||
                     (w_state_next == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (w_state_next != S_IDLE) begin
            r_cnt     <= '0;
            r_work_hi <= '0;
            r_work_lo <= w_a_mag;
            r_operand <= w_b_mag;
            r_is_mult <= (w_state_next == S_MULT);
`ifdef MULTDIV_SIGNED_EN
            r_neg_res <= bus.A_in[WIDTH-1] ^ bus.B_in[WIDTH-1];
            r_neg_rem <= bus.A_in[WIDTH-1];
`endif
          end
        end
        S_MULT, S_DIV: begin
          r_work_hi <= w_step_hi;
          r_work_lo <= w_step_lo;
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Hi       = r_hi;
  assign bus.Lo       = r_lo;
  assign bus.MultStop = r_mult_stop;
  assign bus.DivStop  = r_div_stop;
  assign bus.DivZero  = r_div_zero;
  assign bus.Busy     = r_busy;

endmodule

`default_nettype wire
